// File: rtl/pe_a_skew_feeder.sv
// Row-operand feeder: skews each accepted A column so PE row r sees lane r r advances after lane 0.
// Latency: row 0 one cycle after accept; flush of NUM-1 cycles after the last column; stalls with input gaps.
module pe_a_skew_feeder #(
  parameter int NUM = 16,
  parameter int DW  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic              in_last_i,
  input  logic [NUM*DW-1:0] in_a_i,
  output logic [NUM*DW-1:0] a_left_o,
  output logic              out_en_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [15:0]       beat_cnt_o
);

  localparam int CW = (NUM > 1) ? $clog2(NUM) : 1;

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_e;

  state_e          state_q;
  logic [CW-1:0]   flush_q;
  logic            out_en_q;
  logic            done_q;
  logic [15:0]     beat_q;
  logic            accept;
  logic            advance;

  assign in_ready_o = (state_q != FLUSH);
  assign accept     = in_valid_i & in_ready_o;
  assign advance    = accept | (state_q == FLUSH);

  assign out_en_o   = out_en_q;
  assign done_o     = done_q;
  assign busy_o     = (state_q != IDLE);
  assign beat_cnt_o = beat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      flush_q  <= '0;
      out_en_q <= 1'b0;
      done_q   <= 1'b0;
      beat_q   <= '0;
    end else begin
      out_en_q <= advance;
      done_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            beat_q <= 16'd1;
            if (!in_last_i) begin
              state_q <= STREAM;
            end else if (NUM > 1) begin
              state_q <= FLUSH;
              flush_q <= CW'(NUM - 1);
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        STREAM: begin
          if (accept) begin
            if (beat_q != 16'hFFFF) beat_q <= beat_q + 16'd1;
            if (in_last_i) begin
              if (NUM > 1) begin
                state_q <= FLUSH;
                flush_q <= CW'(NUM - 1);
              end else begin
                state_q <= IDLE;
                done_q  <= 1'b1;
              end
            end
          end
        end
        FLUSH: begin
          // DONE lands on the same cycle as the final flush OUT_EN
          flush_q <= flush_q - CW'(1);
          if (flush_q == CW'(1)) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Lane r delay line of r+1 stages; zeros enter during flush so no residue survives a stream.
  for (genvar r = 0; r < NUM; r++) begin : g_lane
    logic [DW-1:0] chain_q [r+1];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int j = 0; j <= r; j++) chain_q[j] <= '0;
      end else if (advance) begin
        chain_q[0] <= accept ? in_a_i[r*DW +: DW] : '0;
        for (int j = 1; j <= r; j++) chain_q[j] <= chain_q[j-1];
      end
    end

    assign a_left_o[r*DW +: DW] = chain_q[r];
  end

endmodule

// File: tb/tb_pe_a_skew_feeder.sv
// Bench for pe_a_skew_feeder: NUM=4 instance against a column-history model, plus a NUM=1 instance.
module tb_pe_a_skew_feeder;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int BW = N * W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic [BW-1:0] in_a = '0;
  logic          in_ready;
  logic [BW-1:0] a_left;
  logic          out_en, busy, done;
  logic [15:0]   beat_cnt;

  logic          v1 = 1'b0;
  logic          l1 = 1'b0;
  logic [W-1:0]  a1 = '0;
  logic          rdy1, en1, busy1, done1;
  logic [W-1:0]  al1;
  logic [15:0]   bc1;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: history of columns entering the array, one entry per advance.
  logic [BW-1:0] hist [$];
  int            flush_left = 0;
  bit            streaming  = 0;
  int            beats      = 0;
  bit            exp_en     = 0;
  bit            exp_done   = 0;
  int            en_seen    = 0;
  int            done_seen  = 0;

  always #5 clk = ~clk;

  pe_a_skew_feeder #(.NUM(N), .DW(W)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_last_i(in_last), .in_a_i(in_a), .a_left_o(a_left), .out_en_o(out_en),
    .busy_o(busy), .done_o(done), .beat_cnt_o(beat_cnt)
  );

  pe_a_skew_feeder #(.NUM(1), .DW(W)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid_i(v1), .in_ready_o(rdy1),
    .in_last_i(l1), .in_a_i(a1), .a_left_o(al1), .out_en_o(en1),
    .busy_o(busy1), .done_o(done1), .beat_cnt_o(bc1)
  );

  task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [BW-1:0] exp_a_left();
    logic [BW-1:0] e;
    int idx;
    e = '0;
    for (int r = 0; r < N; r++) begin
      idx = hist.size() - 1 - r;
      if (idx >= 0) e[r*W +: W] = hist[idx][r*W +: W];
    end
    return e;
  endfunction

  task automatic check_all();
    chk("a_left",   a_left,   exp_a_left());
    chk("out_en",   out_en,   exp_en);
    chk("done",     done,     exp_done);
    chk("in_ready", in_ready, flush_left == 0);
    chk("busy",     busy,     streaming || flush_left > 0);
    chk("beat_cnt", beat_cnt, beats[15:0]);
    if (out_en) en_seen++;
    if (done)   done_seen++;
  endtask

  // Drive one cycle from a negedge, update the model for the coming edge, check at the next negedge.
  task automatic step(input bit v, input bit l, input logic [BW-1:0] a);
    bit acc;
    in_valid = v;
    in_last  = l;
    in_a     = a;
    acc      = v && (flush_left == 0);
    exp_done = 0;
    exp_en   = acc || (flush_left > 0);
    if (acc) begin
      beats = streaming ? ((beats == 65535) ? 65535 : beats + 1) : 1;
      hist.push_back(a);
      if (l) begin
        streaming  = 0;
        flush_left = N - 1;
      end else begin
        streaming = 1;
      end
    end else if (flush_left > 0) begin
      hist.push_back('0);
      flush_left--;
      if (flush_left == 0) exp_done = 1;
    end
    while (hist.size() > N) void'(hist.pop_front());
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_a_left", a_left, '0);
    chk("rst_out_en", out_en, 1'b0);
    chk("rst_busy",   busy,   1'b0);
    chk("rst_done",   done,   1'b0);
    chk("rst_beat",   beat_cnt, '0);
    hist.delete();
    flush_left = 0;
    streaming  = 0;
    beats      = 0;
    exp_en     = 0;
    exp_done   = 0;
    in_valid   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [BW-1:0] col(input int k);
    logic [BW-1:0] c;
    for (int r = 0; r < N; r++) c[r*W +: W] = W'(10 * k + r);
    return c;
  endfunction

  function automatic logic [BW-1:0] rnd_col();
    logic [BW-1:0] c;
    for (int r = 0; r < N; r++) c[r*W +: W] = $urandom;
    return c;
  endfunction

  initial begin
    logic [BW-1:0] c;
    @(negedge clk);
    do_reset();
    check_all();

    // Single column {4,3,2,1} with last
    en_seen = 0; done_seen = 0;
    c = {32'd4, 32'd3, 32'd2, 32'd1};
    step(1, 1, c);
    chk("t1_row0", a_left, {96'd0, 32'd1});
    for (int i = 0; i < 5; i++) step(0, 0, '0);
    chk("t1_en_count",   en_seen,   4);
    chk("t1_done_count", done_seen, 1);

    // Three back-to-back columns
    en_seen = 0; done_seen = 0;
    for (int k = 0; k < 3; k++) step(1, k == 2, col(k));
    chk("t2_beats", beat_cnt, 16'd3);
    for (int i = 0; i < 5; i++) step(0, 0, '0);
    chk("t2_en_count",   en_seen,   6);
    chk("t2_done_count", done_seen, 1);

    // Same with a two-cycle gap before the last column
    en_seen = 0;
    step(1, 0, col(0));
    step(1, 0, col(1));
    step(0, 1, '1);
    step(0, 0, '0);
    step(1, 1, col(2));
    for (int i = 0; i < 5; i++) step(0, 0, '0);
    chk("t3_en_count", en_seen, 6);

    // Valid held through flush with a new column
    step(1, 1, col(5));
    for (int i = 0; i < 4; i++) step(1, 0, col(7));
    chk("t4_no_residue", a_left[BW-1:W], '0);
    for (int i = 0; i < 5; i++) step(0, 0, '0);

    // Reset mid-stream, then single column again
    done_seen = 0;
    step(1, 0, col(1));
    step(1, 0, col(2));
    do_reset();
    check_all();
    en_seen = 0;
    step(1, 1, {32'd4, 32'd3, 32'd2, 32'd1});
    for (int i = 0; i < 5; i++) step(0, 0, '0);
    chk("t5_en_count",   en_seen,   4);
    chk("t5_done_count", done_seen, 1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
        check_all();
      end else begin
        step($urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0, rnd_col());
      end
    end
    in_valid = 1'b0;

    // NUM=1 instance
    for (int k = 0; k < 3; k++) begin
      v1 = 1'b1;
      l1 = (k != 1);
      a1 = W'(32'hA500 + k);
      @(posedge clk);
      @(negedge clk);
      chk("n1_a_left", al1, W'(32'hA500 + k));
      chk("n1_en",     en1, 1'b1);
      chk("n1_done",   done1, l1);
      chk("n1_ready",  rdy1, 1'b1);
      chk("n1_busy",   busy1, !l1);
    end
    v1 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("n1_en_idle", en1, 1'b0);
    chk("n1_hold",    al1, W'(32'hA502));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
